// File: rtl/e203_exu_csr_xctrl.sv
// rtl/e203_exu_csr_xctrl.sv - CSR access controller for core CSR file and external CSR channels
module e203_exu_csr_xctrl #(
  parameter int XLEN    = 32,
  parameter int NCH     = 2,
  parameter int TMO_W   = 8,
  parameter int TMO_MAX = 200
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            csr_i_valid,
  output logic            csr_i_ready,
  input  logic [XLEN-1:0] csr_i_rs1,
  input  logic [2:0]      csr_i_op,
  input  logic            csr_i_rs1imm,
  input  logic            csr_i_rs1is0,
  input  logic [4:0]      csr_i_zimm,
  input  logic [11:0]     csr_i_idx,
  input  logic            csr_i_rdwen,
  output logic            csr_ena,
  output logic            csr_rd_en,
  output logic            csr_wr_en,
  output logic [11:0]     csr_idx,
  output logic [XLEN-1:0] csr_wdat,
  input  logic [XLEN-1:0] read_csr_dat,
  input  logic            csr_access_ilgl,
  input  logic [NCH-1:0]  x_off,
  output logic            x_req_valid,
  input  logic            x_req_ready,
  output logic [1:0]      x_req_ch,
  output logic [11:0]     x_req_addr,
  output logic            x_req_wr,
  output logic [XLEN-1:0] x_req_wdata,
  input  logic            x_rsp_valid,
  input  logic [XLEN-1:0] x_rsp_rdata,
  input  logic            x_rsp_err,
  output logic            csr_o_valid,
  input  logic            csr_o_ready,
  output logic [XLEN-1:0] csr_o_wdat,
  output logic            csr_o_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_RREQ, S_RWAIT, S_WREQ, S_WWAIT, S_DONE
  } state_t;

  // op is one-hot {rc,rs,rw}
  function automatic logic [XLEN-1:0] f_newval(input logic [2:0] op,
                                               input logic [XLEN-1:0] op1,
                                               input logic [XLEN-1:0] old);
    logic [XLEN-1:0] v;
    v = '0;
    if (op[0])      v = op1;
    else if (op[1]) v = op1 | old;
    else if (op[2]) v = ~op1 & old;
    return v;
  endfunction

  state_t            r_state;
  logic              r_o_vld;
  logic [XLEN-1:0]   r_o_wdat;
  logic              r_o_err;
  logic [2:0]        r_op;
  logic [XLEN-1:0]   r_op1;
  logic [11:0]       r_idx;
  logic [1:0]        r_ch;
  logic              r_wr_need;
  logic [XLEN-1:0]   r_rdata;
  logic              r_err;
  logic [TMO_W-1:0]  r_tmo;

  logic [XLEN-1:0]   w_op1;
  logic              w_rd_need;
  logic              w_wr_need;
  logic [3:0]        w_nib;
  logic [3:0]        w_chf;
  logic              w_ext;
  logic [3:0]        w_off_vec;
  logic              w_off;
  logic              w_acc;
  logic              w_tmo_hit;

  assign w_op1     = csr_i_rs1imm ? {{(XLEN-5){1'b0}}, csr_i_zimm} : csr_i_rs1;
  assign w_rd_need = (csr_i_op[0] & csr_i_rdwen) | csr_i_op[1] | csr_i_op[2];
  assign w_wr_need = csr_i_op[0] | ((csr_i_op[1] | csr_i_op[2]) & ~csr_i_rs1is0);

  // Channel c owns CSR index nibble 0xC + c
  assign w_nib = csr_i_idx[11:8];
  assign w_chf = w_nib - 4'hC;
  assign w_ext = (w_nib >= 4'hC) && (w_chf < 4'(NCH));

  // Widen x_off to four channels so any channel number can index it
  always_comb begin
    w_off_vec = '0;
    w_off_vec[NCH-1:0] = x_off;
  end
  assign w_off = w_off_vec[w_chf[1:0]];

  assign csr_i_ready = (r_state == S_IDLE) & ~r_o_vld;
  assign w_acc       = csr_i_valid & csr_i_ready;
  assign w_tmo_hit   = (r_tmo == TMO_W'(TMO_MAX - 1));

  // Core CSR file is accessed combinationally in the accept cycle
  assign csr_ena   = w_acc & ~w_ext;
  assign csr_rd_en = csr_ena & w_rd_need;
  assign csr_wr_en = csr_ena & w_wr_need;
  assign csr_idx   = csr_ena ? csr_i_idx : 12'h0;
  assign csr_wdat  = csr_ena ? f_newval(csr_i_op, w_op1, read_csr_dat) : '0;

  // External request fields come straight from registers, so they hold while valid
  assign x_req_valid = (r_state == S_RREQ) | (r_state == S_WREQ);
  assign x_req_wr    = (r_state == S_WREQ);
  assign x_req_ch    = r_ch;
  assign x_req_addr  = r_idx;
  assign x_req_wdata = (r_state == S_WREQ) ? f_newval(r_op, r_op1, r_rdata) : '0;

  assign csr_o_valid = r_o_vld;
  assign csr_o_wdat  = r_o_wdat;
  assign csr_o_err   = r_o_err;

  // External-channel FSM plus the one-entry result register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_o_vld   <= 1'b0;
      r_o_wdat  <= '0;
      r_o_err   <= 1'b0;
      r_op      <= '0;
      r_op1     <= '0;
      r_idx     <= '0;
      r_ch      <= '0;
      r_wr_need <= 1'b0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
      r_tmo     <= '0;
    end else begin
      if (r_o_vld && csr_o_ready) r_o_vld <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_acc) begin
            if (!w_ext) begin
              r_o_vld  <= 1'b1;
              r_o_wdat <= read_csr_dat;
              r_o_err  <= csr_access_ilgl;
            end else if (w_off) begin
              // Disabled channel: fail locally, nothing goes on the bus
              r_o_vld  <= 1'b1;
              r_o_wdat <= '0;
              r_o_err  <= 1'b1;
            end else begin
              r_op      <= csr_i_op;
              r_op1     <= w_op1;
              r_idx     <= csr_i_idx;
              r_ch      <= w_chf[1:0];
              r_wr_need <= w_wr_need;
              r_rdata   <= '0;
              r_err     <= 1'b0;
              r_state   <= w_rd_need ? S_RREQ : S_WREQ;
            end
          end
        end
        S_RREQ: begin
          if (x_req_ready) begin
            r_tmo   <= '0;
            r_state <= S_RWAIT;
          end
        end
        S_RWAIT: begin
          if (x_rsp_valid) begin
            r_rdata <= x_rsp_rdata;
            if (x_rsp_err) begin
              r_err   <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_state <= r_wr_need ? S_WREQ : S_DONE;
            end
          end else if (w_tmo_hit) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        S_WREQ: begin
          if (x_req_ready) begin
            r_tmo   <= '0;
            r_state <= S_WWAIT;
          end
        end
        S_WWAIT: begin
          if (x_rsp_valid) begin
            r_err   <= x_rsp_err;
            r_state <= S_DONE;
          end else if (w_tmo_hit) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        S_DONE: begin
          r_o_vld  <= 1'b1;
          r_o_wdat <= r_rdata;
          r_o_err  <= r_err;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
